// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - programmable cyclic phase sequencer with one-shot/free-run modes
module phase_sequencer #(
  parameter int MAX_PHASES  = 8,
  parameter int CNT_W       = $clog2(MAX_PHASES),
  parameter int DEFAULT_LEN = 3,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  oneshot,
  input  logic                  dir,
  input  logic                  len_load,
  input  logic [CNT_W-1:0]      len_in,
  output logic [CNT_W-1:0]      phase,
  output logic [MAX_PHASES-1:0] phase_onehot,
  output logic                  y,
  output logic                  wrap,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W:0]   MAX_W     = (CNT_W+1)'(MAX_PHASES);
  localparam logic [CNT_W-1:0] LAST_MAX  = CNT_W'(MAX_PHASES - 1);
  localparam logic [CNT_W-1:0] LAST_RST  = CNT_W'(DEFAULT_LEN - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam state_t           STATE_RST = AUTO_START ? S_RUN : S_IDLE;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] phase_nxt;
  logic [CNT_W-1:0] last, last_nxt;
  logic [CNT_W-1:0] len_clamped;
  logic [CNT_W-1:0] last_eff;
  logic             mode_os, mode_os_nxt;
  logic             wrap_nxt, done_nxt;

  // Clamp the requested last index; a same-edge load governs this cycle's step.
  always_comb begin
    len_clamped = ({1'b0, len_in} >= MAX_W) ? LAST_MAX : len_in;
    last_eff    = len_load ? len_clamped : last;
  end

  // Next-state, next-phase and event-pulse decode.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    last_nxt    = len_load ? len_clamped : last;
    mode_os_nxt = mode_os;
    wrap_nxt    = 1'b0;
    done_nxt    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_RUN;
          mode_os_nxt = oneshot;
          phase_nxt   = dir ? last_eff : '0;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (len_load && (phase > last_eff)) begin
          // Shrinking below the current phase restarts the pass silently.
          phase_nxt = '0;
        end else if (en) begin
          if (!dir) begin
            if (phase < last_eff) begin
              phase_nxt = phase + ONE;
            end else if (mode_os) begin
              phase_nxt = '0;
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else begin
              phase_nxt = '0;
              wrap_nxt  = 1'b1;
            end
          end else begin
            if (phase != '0) begin
              phase_nxt = phase - ONE;
            end else if (mode_os) begin
              phase_nxt = '0;
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else begin
              phase_nxt = last_eff;
              wrap_nxt  = 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        phase_nxt = '0;
      end
    endcase

    // A held phase must never sit beyond a freshly shortened length.
    if (phase_nxt > last_eff) begin
      phase_nxt = '0;
    end
  end

  // State, phase, length and event registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= STATE_RST;
      phase   <= '0;
      last    <= LAST_RST;
      mode_os <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      last    <= last_nxt;
      mode_os <= mode_os_nxt;
      wrap    <= wrap_nxt;
      done    <= done_nxt;
    end
  end

  // Phase decodes derived directly from the phase register.
  always_comb begin
    phase_onehot        = '0;
    phase_onehot[phase] = 1'b1;
    y                   = (phase == '0);
    busy                = (state == S_RUN);
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, start, stop, oneshot, dir, len_load;
  logic [2:0] len_in;
  logic [2:0] phase;
  logic [7:0] phase_onehot;
  logic       y, wrap, done, busy;

  int n_cmp = 0;
  int n_err = 0;

  phase_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .start        (start),
    .stop         (stop),
    .oneshot      (oneshot),
    .dir          (dir),
    .len_load     (len_load),
    .len_in       (len_in),
    .phase        (phase),
    .phase_onehot (phase_onehot),
    .y            (y),
    .wrap         (wrap),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int exp_ph, input bit exp_wrap,
                        input bit exp_done, input bit exp_busy);
    chk({tag, ".phase"}, 32'(phase), 32'(exp_ph));
    chk({tag, ".wrap"},  32'(wrap),  32'(exp_wrap));
    chk({tag, ".done"},  32'(done),  32'(exp_done));
    chk({tag, ".busy"},  32'(busy),  32'(exp_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    dir = 1'b0; len_load = 1'b0; len_in = 3'd0;
    step(); step();
    chk_st("rst", 0, 0, 0, 1);
    chk("rst.y", 32'(y), 32'd1);
    chk("rst.onehot", 32'(phase_onehot), 32'h01);

    // free-run up, default length 3
    reset = 1'b0; en = 1'b1;
    step(); chk_st("up1", 1, 0, 0, 1); chk("up1.y", 32'(y), 32'd0);
    step(); chk_st("up2", 2, 0, 0, 1);
    step(); chk_st("up0", 0, 1, 0, 1); chk("up0.y", 32'(y), 32'd1);
    step(); chk_st("up1b", 1, 0, 0, 1);
    step(); chk_st("up2b", 2, 0, 0, 1);
    step(); chk_st("up0b", 0, 1, 0, 1);

    // free-run down
    dir = 1'b1;
    step(); chk_st("dn2", 2, 1, 0, 1); chk("dn2.onehot", 32'(phase_onehot), 32'h04);
    step(); chk_st("dn1", 1, 0, 0, 1); chk("dn1.onehot", 32'(phase_onehot), 32'h02);
    step(); chk_st("dn0", 0, 0, 0, 1); chk("dn0.onehot", 32'(phase_onehot), 32'h01);
    step(); chk_st("dn2b", 2, 1, 0, 1);

    // enable gating
    dir = 1'b0;
    step(); chk_st("en_a", 0, 1, 0, 1);
    en = 1'b0;
    step(); chk_st("hold1", 0, 0, 0, 1);
    step(); chk_st("hold2", 0, 0, 0, 1);
    en = 1'b1;
    step(); chk_st("en_b", 1, 0, 0, 1);

    // lengthen to 8 phases, run to phase 5, then shrink below it
    len_load = 1'b1; len_in = 3'd7;
    step(); chk_st("len7", 2, 0, 0, 1);
    len_load = 1'b0;
    step(); step(); step(); chk_st("at5", 5, 0, 0, 1);
    len_load = 1'b1; len_in = 3'd3;
    step(); chk_st("shrink", 0, 0, 0, 1);
    len_load = 1'b0;
    step(); step(); step(); chk_st("l3_3", 3, 0, 0, 1);
    step(); chk_st("l3_w", 0, 1, 0, 1);

    // stop at the terminal phase beats the wrap
    step(); step(); step(); chk_st("pre_stop", 3, 0, 0, 1);
    stop = 1'b1;
    step(); chk_st("stop", 3, 0, 0, 0);
    step(); chk_st("idle", 3, 0, 0, 0);
    stop = 1'b0;

    // one-shot up pass over 5 phases
    len_load = 1'b1; len_in = 3'd4;
    step(); chk_st("idle_len", 3, 0, 0, 0);
    len_load = 1'b0; start = 1'b1; oneshot = 1'b1;
    step(); chk_st("os_st", 0, 0, 0, 1);
    start = 1'b0; oneshot = 1'b0;
    step(); step(); step(); step(); chk_st("os4", 4, 0, 0, 1);
    start = 1'b1;
    step(); chk_st("os_done", 0, 0, 1, 0);
    step(); chk_st("os_idle", 0, 0, 0, 0);
    start = 1'b0;
    step(); chk_st("os_idle2", 0, 0, 0, 0);

    // one-shot down pass starts at last
    start = 1'b1; oneshot = 1'b1; dir = 1'b1;
    step(); chk_st("osd_st", 4, 0, 0, 1);
    start = 1'b0;
    step(); step(); step(); step(); chk_st("osd0", 0, 0, 0, 1);
    step(); chk_st("osd_done", 0, 0, 1, 0);
    step(); chk_st("osd_idle", 0, 0, 0, 0);

    // asynchronous reset in the middle of a one-shot pass
    start = 1'b1; dir = 1'b0;
    step(); start = 1'b0;
    step(); step(); step(); step(); chk_st("pre_rst", 4, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    chk_st("arst", 0, 0, 0, 1);
    chk("arst.y", 32'(y), 32'd1);
    step(); reset = 1'b0;
    step(); chk_st("post_rst1", 1, 0, 0, 1);
    step(); chk_st("post_rst2", 2, 0, 0, 1);
    step(); chk_st("post_rst0", 0, 1, 0, 1);

    // length 1: every enabled cycle wraps
    step();
    len_load = 1'b1; len_in = 3'd0;
    step(); chk_st("l1_a", 0, 0, 0, 1);
    len_load = 1'b0;
    step(); chk_st("l1_b", 0, 1, 0, 1);
    step(); chk_st("l1_c", 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised cyclic phase sequencer for control-unit timing. Steps a phase index through a run-time programmable length (1..MAX_PHASES), counting up or down, in free-run or one-shot mode. Provides start/stop/enable control, a phase-0 strobe, a one-hot phase vector, and wrap/done event pulses. It replaces fixed 3-state ring FSMs in the control unit; with defaults it reproduces the legacy 3-phase cycle with y high in phase 0.

Parameters:
MAX_PHASES, 8, maximum sequence length; must be >= 2.
CNT_W, $clog2(MAX_PHASES), phase/length field width; derived, not overridden.
DEFAULT_LEN, 3, sequence length after reset; range 1..MAX_PHASES.
AUTO_START, 1, 1: leave reset directly in RUN, free-running, counting up; 0: leave reset in IDLE.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  advance qualifier in RUN; 0 holds the phase
start  in  1  IDLE->RUN request; ignored outside IDLE
stop  in  1  RUN->IDLE abort; ignored outside RUN
oneshot  in  1  mode, latched on start: 1 = single pass, 0 = free-run
dir  in  1  0 = up, 1 = down; sampled on every advance
len_load  in  1  load len_in into the length register
len_in  in  CNT_W  last phase index (length-1); values >= MAX_PHASES clamp to MAX_PHASES-1
phase  out  CNT_W  current phase index, registered
phase_onehot  out  MAX_PHASES  bit[phase] set, combinational from phase
y  out  1  phase == 0, combinational
wrap  out  1  registered 1-cycle pulse: a free-run pass completed
done  out  1  registered 1-cycle pulse: one-shot pass completed
busy  out  1  FSM in RUN

Behaviour:
- Control FSM states: IDLE, RUN, DONE. last = length register value.
- Reset (async, any time): FSM = RUN if AUTO_START else IDLE; phase=0; last=DEFAULT_LEN-1; oneshot latch=0; wrap=0; done=0. Consequently y=1, phase_onehot=1, busy=AUTO_START.
- IDLE: start=1 -> RUN. Latch oneshot. Load phase = 0 if dir=0, else last. stop is ignored. phase holds otherwise.
- RUN, stop=1: -> IDLE and phase holds. stop has priority over en and over the wrap/terminal step.
- RUN, en=0: hold everything.
- RUN, en=1, up: phase<last -> phase+1. phase==last: free-run -> phase=0 and wrap=1 next cycle; one-shot -> phase=0, FSM=DONE, done=1 next cycle.
- RUN, en=1, down: phase>0 -> phase-1. phase==0: free-run -> phase=last and wrap=1; one-shot -> phase=0, DONE, done=1.
- last==0 (length 1): every enabled cycle is terminal. In free-run, wrap is high continuously while en=1.
- DONE: lasts exactly 1 cycle, then unconditionally -> IDLE. start, stop and en are ignored in DONE.
- len_load (any state, same edge): last = clamp(len_in). If in RUN and the current phase > new last, phase=0 next cycle instead of the normal step; no wrap or done is generated.
- A dir change mid-sequence takes effect on the next advance with no extra cycle.
- Phase arithmetic is mod (last+1) and never leaves 0..last.
- wrap and done are never high together.

Test Plan:
- Defaults, release reset, en=1 -> phase 0,1,2,0,1,2; y=1,0,0,1; wrap=1 on each cycle where phase returns to 0.
- AUTO_START=0, len_load len_in=4, start with oneshot=1, dir=0, en=1 -> phase 0..4, then DONE: done=1 for 1 cycle with phase=0, busy=0 after, wrap never asserted.
- Free-run, dir=1, last=2 -> phase 2,1,0,2,1; wrap pulses after the 0->2 step; phase_onehot tracks as 100,010,001.
- RUN at phase=5 (last=7), len_load len_in=3 -> phase=0 next cycle, no wrap; then 0..3 cyclic.
- en toggled 1,0,0,1 -> phase holds over the 2 idle cycles. stop asserted with en=1 at phase==last -> IDLE, phase stays at last, no wrap.
- Assert reset mid-pass (phase=4, one-shot) -> immediately phase=0, y=1, done=0, wrap=0, FSM per AUTO_START.
